// File: rtl/div_iter_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  // EX stage side: issues requests, consumes {HI, LO}
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for div/divu.
// One quotient bit per cycle, fixed 32-cycle iteration, sign fixup on exit.
// result = {remainder, quotient} = {HI, LO}; all outputs registered.
module div_iter (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state, nxt;
  logic [5:0]  cnt;
  logic [31:0] quo;      // dividend shifts out the top, quotient bits enter at the bottom
  logic [31:0] rem;      // partial remainder, always < divisor between iterations
  logic [31:0] dsr;      // |divisor|
  logic        sgn;      // signed operation latched at start
  logic        sign1;    // dividend sign
  logic        sign2;    // divisor sign
  logic [63:0] result;
  logic        ready;

  logic        go;
  logic        dsr_zero;
  logic [31:0] abs1, abs2;
  logic [32:0] shifted;
  logic        fit;
  logic [31:0] diff;
  logic [31:0] quo_nxt, rem_nxt;
  logic [31:0] quo_fix, rem_fix;
  logic        last;

  assign go       = bus.start_i && !bus.annul_i;
  assign dsr_zero = (bus.opdata2_i == 32'd0);
  assign last     = (cnt == 6'd31);

  // Magnitudes of the incoming operands; 0x80000000 negates to itself and
  // is then simply read as unsigned 2^31.
  always_comb begin
    abs1 = bus.opdata1_i;
    abs2 = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[31]) abs1 = ~bus.opdata1_i + 32'd1;
    if (bus.signed_div_i && bus.opdata2_i[31]) abs2 = ~bus.opdata2_i + 32'd1;
  end

  // One restoring shift-subtract step plus the sign fixup used on the last step.
  // The true difference is below the divisor when it fits, so 32 bits suffice.
  always_comb begin
    shifted = {rem, quo[31]};
    fit     = (shifted >= {1'b0, dsr});
    diff    = shifted[31:0] - dsr;
    rem_nxt = fit ? diff : shifted[31:0];
    quo_nxt = {quo[30:0], fit};
    quo_fix = quo_nxt;
    rem_fix = rem_nxt;
    if (sgn && (sign1 ^ sign2)) quo_fix = ~quo_nxt + 32'd1;
    if (sgn && sign1)           rem_fix = ~rem_nxt + 32'd1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FREE;
    else     state <= nxt;
  end

  // Next-state logic; annul wins everywhere except END, where it is ignored
  always_comb begin
    nxt = state;
    case (state)
      FREE: begin
        if (go) nxt = dsr_zero ? BYZERO : ON;
      end
      BYZERO: begin
        nxt = bus.annul_i ? FREE : END;
      end
      ON: begin
        if (bus.annul_i) nxt = FREE;
        else if (last)   nxt = END;
      end
      END: begin
        if (!bus.start_i) nxt = FREE;
      end
      default: nxt = FREE;
    endcase
  end

  // Datapath: operand capture, iteration, result/ready registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 6'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      dsr    <= 32'd0;
      sgn    <= 1'b0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      result <= 64'd0;
      ready  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (go && !dsr_zero) begin
            quo   <= abs1;
            rem   <= 32'd0;
            dsr   <= abs2;
            sgn   <= bus.signed_div_i;
            sign1 <= bus.opdata1_i[31];
            sign2 <= bus.opdata2_i[31];
            cnt   <= 6'd0;
          end
        end
        BYZERO: begin
          if (!bus.annul_i) begin
            result <= 64'd0;
            ready  <= 1'b1;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            cnt <= 6'd0;
            quo <= 32'd0;
            rem <= 32'd0;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 6'd1;
            if (last) begin
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
            end
          end
        end
        END: begin
          if (!bus.start_i) begin
            result <= 64'd0;
            ready  <= 1'b0;
            cnt    <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corners plus random operands
// against an arithmetic reference model.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  div_iter_if bus ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int ITER_EDGES = 32;  // edges after the sampling edge until ready
  localparam int ZERO_EDGES = 1;

  // Reference: divide magnitudes, then apply the sign rules, all mod 2^32
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (sd && a[31]) ? (32'd0 - a) : a;
    ub = (sd && b[31]) ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sd && (a[31] != b[31])) q = 32'd0 - q;
    if (sd && a[31])            r = 32'd0 - r;
    return {r, q};
  endfunction

  // Issue one request and wait for ready; edges = -1 on timeout.
  // Operands are scrambled after the sampling edge, which must not matter.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic [63:0] res);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sd;
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) begin
        edges = i;
        break;
      end
    end
    res = bus.result_o;
  endtask

  task automatic check_op(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b);
    int          edges;
    logic [63:0] res, exp;
    int          exp_edges;
    exp       = model(sd, a, b);
    exp_edges = (b == 32'd0) ? ZERO_EDGES : ITER_EDGES;
    run_op(sd, a, b, edges, res);
    n_vec++;
    if (edges !== exp_edges) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, edges, exp_edges);
    end
    n_vec++;
    if (res !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h, want %h (sd=%0b a=%h b=%h)", name, res, exp, sd, a, b);
    end
    // drop start: outputs clear on the next edge
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL %s drop: got ready=%b result=%h, want 0/0", name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL reset ready: got %b want 0", bus.ready_o); end
    n_vec++;
    if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL reset result: got %h want 0", bus.result_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int          edges;
    logic [63:0] res;
    // 100 / 7 against hand constant as well as the model
    run_op(1'b0, 32'd100, 32'd7, edges, res);
    n_vec++;
    if (edges !== ITER_EDGES || res !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL u100/7: got edges=%0d res=%h, want %0d %h", edges, res, ITER_EDGES, {32'd2, 32'd14});
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL u100/7 drop: got ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    check_op("s-7/2",         1'b1, 32'hFFFF_FFF9, 32'h2);
    check_op("u-7/2",         1'b0, 32'hFFFF_FFF9, 32'h2);
    check_op("s_ovf",         1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("u_ovf",         1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("s7/-2",         1'b1, 32'd7,         32'hFFFF_FFFE);
    check_op("s-8/-3",        1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
    check_op("u_small_big",   1'b0, 32'd5,         32'hFFFF_FFFF);
    // explicit constants for the corner rows
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, res);
    n_vec++;
    if (res !== {32'h0, 32'h8000_0000}) begin
      n_err++; $display("FAIL s_ovf_const: got %h want %h", res, {32'h0, 32'h8000_0000});
    end
    @(negedge clk); bus.start_i = 1'b0; @(posedge clk);
  endtask

  task automatic test_byzero();
    check_op("u_by0", 1'b0, 32'd12345, 32'd0);
    check_op("s_by0", 1'b1, 32'd12345, 32'd0);
    check_op("after_by0", 1'b0, 32'd9, 32'd3);
  endtask

  task automatic test_annul();
    int seen = 0;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);            // sampling edge, cnt=0
    repeat (10) @(posedge clk); // cnt=10
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o || bus.result_o != 64'd0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL annul: got %0d cycles with output activity, want 0", seen); end
    check_op("after_annul", 1'b0, 32'hFFFF_FFFF, 32'h10);
    // annul together with start in FREE must not launch anything
    @(negedge clk);
    bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1; bus.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL annul_free: got %0d ready cycles, want 0", seen); end
  endtask

  task automatic test_hold();
    int          edges;
    logic [63:0] res, exp;
    exp = model(1'b0, 32'd77777, 32'd13);
    run_op(1'b0, 32'd77777, 32'd13, edges, res);
    n_vec++;
    if (res !== exp) begin n_err++; $display("FAIL hold first: got %h want %h", res, exp); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
        n_err++;
        $display("FAIL hold cyc%0d: got ready=%b result=%h, want 1/%h", i, bus.ready_o, bus.result_o, exp);
      end
    end
    @(negedge clk); bus.start_i = 1'b0; @(posedge clk);
  endtask

  task automatic test_async_reset();
    int          edges;
    int          seen = 0;
    logic [63:0] res;
    // reset while ready is high: outputs must clear with no clock edge
    run_op(1'b0, 32'd100, 32'd9, edges, res);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL async_end: got ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // reset mid-iteration: no result may appear afterwards
    @(negedge clk);
    bus.opdata1_i = 32'd999; bus.opdata2_i = 32'd4; bus.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++; $display("FAIL async_on: got ready=%b result=%h, want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL async_on idle: got %0d ready cycles, want 0", seen); end
    check_op("after_rst", 1'b1, 32'hFFFF_FF00, 32'd16);
  endtask

  task automatic test_random();
    logic        sd;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      check_op("random", sd, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_byzero();
    test_annul();
    test_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider serving the EX stage's `div`/`divu` path. EX holds `start_i` high with operands and keeps the pipeline stalled until `ready_o` rises. It then drops `start_i` and forwards `result_o` to HI/LO. The block is a four-state FSM that produces one quotient bit per cycle and handles signed/unsigned operation, divide-by-zero and annulment.

## Interface
- No parameters; operand width is fixed at 32.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- signed_div_i  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with `start_i` in FREE.
- opdata1_i  in  32  dividend; sampled in FREE.
- opdata2_i  in  32  divisor; sampled in FREE.
- start_i  in  1  request; must stay high until `ready_o` is seen, then drop.
- annul_i  in  1  abort the current operation (e.g. pipeline flush).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; maps to {HI, LO}.
- ready_o  out  1  result valid; registered.

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor is zero.
  - ON: iterating; 6-bit counter `cnt`.
  - END: result valid.
- FREE
  - `start_i=1`, `annul_i=0`, divisor ≠ 0 → ON. Latch |dividend| and |divisor|, `signed_div_i`, both operand sign bits, and `cnt=0`.
  - `start_i=1`, `annul_i=0`, divisor = 0 → BYZERO.
  - Otherwise stay in FREE.
- Absolute values are taken only when `signed_div_i=1`, using 32-bit two's-complement negation. 0x80000000 maps to 0x80000000 and is treated as unsigned 2^31.
- ON, each cycle, restoring shift-subtract:
  - Partial remainder p is 33 bits. Shift {p, dividend} left by 1 and compare p[32:0] against {1'b0, divisor}.
  - If p ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - `cnt` increments each cycle. When `cnt` reaches 31 (32nd iteration), go to END.
- Sign fixup at the ON→END edge, signed only:
  - Quotient is negated iff dividend sign ≠ divisor sign.
  - Remainder takes the dividend's sign.
  - All arithmetic wraps mod 2^32, so signed 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0.
- BYZERO: next cycle go to END with `result_o = 0`.
- END: `ready_o=1` and `result_o` is held.
  - When `start_i=0`: → FREE, `ready_o←0`, `result_o←0`.
  - While `start_i=1` it stays in END. It does not re-sample operands.
- `annul_i=1` in ON or BYZERO: → FREE next edge. `ready_o` stays 0 and `result_o` stays 0. `annul_i` has priority over `start_i` in FREE and is ignored in END.
- Operand changes after the FREE sampling edge are ignored.
- Async reset, at any time including mid-operation: state FREE, `cnt=0`, `result_o=0`, `ready_o=0`, internal datapath registers cleared.

## Timing
- Let E0 be the edge that samples `start_i` in FREE.
- Non-zero divisor: ON during E1..E32, END after E32. `ready_o` is high in the cycle after E32, i.e. 33 cycles after E0.
- Zero divisor: BYZERO after E0, END after E1. `ready_o` is high 2 cycles after E0.
- `ready_o` stays high as long as `start_i` stays high. It falls on the first edge that sees `start_i=0`, so with EX's protocol it is high for exactly 1 cycle.
- Back-to-back operations: a new `start_i` can be accepted on the edge after returning to FREE. Minimum spacing is 1 idle cycle between ops.
- Latency is data-independent; there is no early termination.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Unsigned 100 / 7 → `ready_o` rises 33 cycles after E0 with `result_o` = {32'd2, 32'd14}. Drop `start_i` → next cycle `ready_o`=0, `result_o`=0, state FREE.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) → q = 0xFFFFFFFD, r = 0xFFFFFFFF. The same operands unsigned → q = 0x7FFFFFFC, r = 0x1.
- Overflow corner 0x80000000 / 0xFFFFFFFF:
  - signed → q = 0x80000000, r = 0;
  - unsigned → q = 0, r = 0x80000000.
- Divide by zero (12345 / 0, both modes) → `ready_o` 2 cycles after E0, `result_o` = 0. A following 9 / 3 → {0, 3} at 33 cycles.
- Assert `annul_i` at `cnt`=10 → FREE next edge, and `ready_o` never rises. A new start of 0xFFFFFFFF / 0x10 unsigned → {0xF, 0x0FFFFFFF}.
- Assert `rst` asynchronously mid-ON and check outputs go 0 without a clock edge. Hold `start_i` high through END for 5 cycles and check `result_o` and `ready_o` stay stable with no restart.
